pipe_hazard_ctrl: RTL
=====================

# pipe_hazard_ctrl

Hazard and sequencing controller for the 5-stage pipeline's ID/EX boundary. Each cycle it decides whether the instruction in ID may enter the ID/EX register, must be held, or must be squashed. It detects load-use hazards against the instruction in EX, tracks the multi-cycle multiply/divide unit with a busy state machine, and applies EX-stage redirects (taken branch or jump). It drives PC write-enable, the IF/ID write-enable and flush, and the ID/EX bubble (control fields zeroed). It also keeps a saturating stall counter for performance checks.

## Interface
Parameters:
- MD_LATENCY, 4, cycles the mult/div unit occupies after issue; legal range 1..15.
- CNT_W, 16, width of the stall counter.

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- id_valid  input  1  the ID stage holds a real instruction.
- id_rs  input  5  rs address of the ID instruction.
- id_rt  input  5  rt address of the ID instruction.
- id_uses_rt  input  1  the ID instruction reads rt as a source.
- id_is_muldiv  input  1  the ID instruction is mult/multu/div/divu.
- id_reads_hilo  input  1  the ID instruction is mfhi/mflo.
- idex_memread  input  1  the EX instruction is a load (taken from the ID/EX M field).
- idex_rt  input  5  destination rt of the EX instruction.
- ex_redirect  input  1  a branch or jump resolved taken in EX this cycle.
- pc_write  output  1  PC update enable.
- ifid_write  output  1  IF/ID register load enable.
- ifid_flush  output  1  turns the IF/ID contents into a NOP.
- idex_bubble  output  1  forces WB/M/EX into ID/EX to zero.
- md_issue  output  1  the mult/div in ID is launched this cycle.
- md_busy  output  1  the mult/div unit is occupied.
- stall_cnt  output  CNT_W  saturating count of stall cycles.

## Operation
- Load-use hazard (combinational), lu:
  - Condition: id_valid & idex_memread & (idex_rt != 0) & (idex_rt == id_rs | (id_uses_rt & idex_rt == id_rt)).
- Mult/div state machine, states IDLE and BUSY, with a 4-bit counter md_cnt:
  - IDLE -> BUSY when md_issue=1; md_cnt loads MD_LATENCY-1.
  - In BUSY: if md_cnt != 0, md_cnt decrements; if md_cnt == 0, go to IDLE.
  - md_busy = (state == BUSY).
- Mult/div hazard, mdh:
  - Condition: md_busy & id_valid & (id_is_muldiv | id_reads_hilo).
- stall = !ex_redirect & (lu | mdh).
- md_issue = id_valid & id_is_muldiv & !md_busy & !stall & !ex_redirect & !rst.
- Output priority (combinational from inputs and state):
  1. rst=1: pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1, md_issue=0.
  2. ex_redirect=1: pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=1. The ID instruction is squashed; hazards are ignored; no issue. An in-flight BUSY continues, because that instruction is older than the branch.
  3. stall=1: pc_write=0, ifid_write=0, ifid_flush=0, idex_bubble=1.
  4. Otherwise: pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0.
- stall_cnt: increments on every edge where stall=1 and rst=0; holds at all-ones (no wrap).
- Reset (sync): state=IDLE, md_cnt=0, stall_cnt=0. md_busy reads 0 from the first cycle after the reset edge. A reset asserted mid-BUSY aborts the operation.

## Timing
- All stall and flush outputs are combinational, so they act in the same cycle the hazard is visible. Only state, md_cnt and stall_cnt are registered.
- Load-use stall lasts exactly 1 cycle. The bubble clears idex_memread on the next edge, so lu deasserts.
- Mult/div: issue in cycle T gives md_busy=1 in cycles T+1..T+MD_LATENCY and 0 at T+MD_LATENCY+1.
  - A dependent mfhi/mflo or second mult/div in ID stalls through T+MD_LATENCY and proceeds or issues in T+MD_LATENCY+1.
- MD_LATENCY=1: exactly one busy cycle.
- lu and mdh in the same cycle: a single stall cycle, counted once.
- A redirect during a stall wins; that cycle is not counted as a stall.

## Test plan
- Load-use: lw $5 in EX (idex_memread=1, idex_rt=5), ID add with id_rs=5 -> one cycle of pc_write=0, ifid_write=0, idex_bubble=1; stall_cnt=1; the next cycle (idex_memread=0) passes.
- $zero and rt-unused cases: idex_rt=0 with id_rs=0, and idex_rt=7 with id_rt=7, id_uses_rt=0 -> no stall; stall_cnt unchanged.
- Mult then mfhi, MD_LATENCY=4:
  - mult issues at T (md_issue=1).
  - mfhi in ID from T+1 -> stalled T+1..T+4 (4 cycles), passes at T+5; stall_cnt=4.
- Redirect priority: ex_redirect=1 together with lu=1 and a mult in ID -> flush=1, bubble=1, pc_write=1, md_issue=0, stall_cnt unchanged. A separately pre-issued BUSY still completes on schedule.
- Reset mid-BUSY: assert rst at T+2 after an issue -> md_busy=0 from T+3 and stall_cnt=0. During rst, pc_write=0 and ifid_flush=1.
- Saturation: force 65540 consecutive stall cycles -> stall_cnt holds 0xFFFF.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Hazard and sequencing controller for the ID/EX boundary of the 5-stage
// pipeline. Decides each cycle whether the ID instruction advances, holds
// or is squashed: load-use detection against EX, a busy tracker for the
// multi-cycle mult/div unit, and EX-stage redirect handling. The control
// outputs are combinational so they act in the cycle the hazard appears;
// only the mult/div state, its countdown and the stall counter are stored.
module pipe_hazard_ctrl #(
    parameter int MD_LATENCY = 4,   // legal range 1..15
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             id_is_muldiv,
    input  logic             id_reads_hilo,
    input  logic             idex_memread,
    input  logic [4:0]       idex_rt,
    input  logic             ex_redirect,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             md_issue,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [0:0] {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    // Countdown reload: the unit stays busy for MD_LATENCY cycles after issue,
    // the last of which is the one where the countdown reads zero.
    localparam logic [3:0]       MD_LOAD = 4'(MD_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    md_state_t        state_r;
    md_state_t        state_nxt_s;
    logic [3:0]       md_cnt_r;
    logic [3:0]       md_cnt_nxt_s;
    logic [CNT_W-1:0] stall_cnt_r;

    logic             rt_match_s;
    logic             rs_match_s;
    logic             lu_s;
    logic             mdh_s;
    logic             stall_s;
    logic             issue_s;
    logic             busy_s;
    logic             cnt_sat_s;

    assign busy_s = (state_r == MD_BUSY);

    // Load-use: a load in EX writes a register the ID instruction reads.
    // Register $zero never carries a real dependency.
    assign rs_match_s = (idex_rt == id_rs);
    assign rt_match_s = id_uses_rt & (idex_rt == id_rt);
    assign lu_s       = id_valid & idex_memread & (idex_rt != 5'd0)
                      & (rs_match_s | rt_match_s);

    // Mult/div hazard: another mult/div or a HI/LO read while the unit works.
    assign mdh_s   = busy_s & id_valid & (id_is_muldiv | id_reads_hilo);

    // A redirect squashes the ID instruction, so its hazards are irrelevant.
    assign stall_s = ~ex_redirect & (lu_s | mdh_s);
    assign issue_s = id_valid & id_is_muldiv & ~busy_s & ~stall_s
                   & ~ex_redirect & ~rst;

    assign cnt_sat_s = &stall_cnt_r;

    // Mult/div busy tracker: next state and countdown value.
    always_comb begin
        state_nxt_s  = state_r;
        md_cnt_nxt_s = md_cnt_r;
        case (state_r)
            MD_IDLE: begin
                if (issue_s) begin
                    state_nxt_s  = MD_BUSY;
                    md_cnt_nxt_s = MD_LOAD;
                end else begin
                    state_nxt_s  = MD_IDLE;
                    md_cnt_nxt_s = md_cnt_r;
                end
            end
            MD_BUSY: begin
                if (md_cnt_r != 4'd0) begin
                    state_nxt_s  = MD_BUSY;
                    md_cnt_nxt_s = md_cnt_r - 4'd1;
                end else begin
                    state_nxt_s  = MD_IDLE;
                    md_cnt_nxt_s = 4'd0;
                end
            end
            default: begin
                state_nxt_s  = MD_IDLE;
                md_cnt_nxt_s = 4'd0;
            end
        endcase
    end

    // Mult/div state register; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= MD_IDLE;
            md_cnt_r <= 4'd0;
        end else begin
            state_r  <= state_nxt_s;
            md_cnt_r <= md_cnt_nxt_s;
        end
    end

    // Stall counter: counts every stalled cycle, sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= '0;
        end else if (stall_s && !cnt_sat_s) begin
            stall_cnt_r <= stall_cnt_r + CNT_ONE;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    // Pipeline control in priority order: reset, redirect, stall, advance.
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        if (rst) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (ex_redirect) begin
            pc_write    = 1'b1;
            ifid_write  = 1'b1;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (stall_s) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b0;
            idex_bubble = 1'b1;
        end else begin
            pc_write    = 1'b1;
            ifid_write  = 1'b1;
            ifid_flush  = 1'b0;
            idex_bubble = 1'b0;
        end
    end

    assign md_issue  = issue_s;
    assign md_busy   = busy_s;
    assign stall_cnt = stall_cnt_r;

endmodule
